// File: rtl/display_scan_decoder.sv
// display_scan_decoder
//   Passive tap on the multiplexed 8-digit seven-segment bus. It watches the
//   anode/cathode scan and decodes each stable digit back to its hex value,
//   enable and decimal point. The result is an 8-digit snapshot that other
//   logic can read. It never drives the display bus.
//
// Ports
//   clock       system clock (same domain as the display driver)
//   reset       synchronous, active-high reset
//   an[7:0]     anode selects, active-low, bit i = digit i
//   dec_cat[7:0] cathodes, active-low, [7:1] = segments a..g, [0] = dp
//   digit_val   decoded hex, digit i at [4i+3:4i]
//   digit_en    digit i lit with a recognised pattern
//   digit_dp    digit i decimal point lit
//   frame_done  one-cycle pulse when the scan wraps around
//   seg_error   one-cycle pulse on an illegal anode or segment pattern
//   stale       no capture for TIMEOUT_CYCLES cycles
module display_scan_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  an,
  input  logic [7:0]  dec_cat,
  output logic [31:0] digit_val,
  output logic [7:0]  digit_en,
  output logic [7:0]  digit_dp,
  output logic        frame_done,
  output logic        seg_error,
  output logic        stale
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {BLANK, SETTLE, HELD} state_t;

  state_t        state_reg;
  logic [15:0]   sample_reg;
  logic [7:0]    cnt_reg;
  logic [TW-1:0] tcnt_reg;
  logic [7:0]    seen_reg;
  logic [2:0]    last_idx_reg;
  logic          have_last_reg;

  logic [7:0]  an_s;
  logic [7:0]  cat_s;
  logic [7:0]  an_low;
  logic        one_hot;
  logic [2:0]  idx_c;
  logic        capture;
  logic        anode_ok;
  logic        wrap;
  logic        timeout_hit;
  logic        seg_ok;
  logic        seg_blank;
  logic        seg_bad;
  logic [3:0]  seg_val;
  logic [31:0] val_next;
  logic [7:0]  en_next;
  logic [7:0]  dp_next;
  logic        port_changed;

  assign an_s   = sample_reg[15:8];
  assign cat_s  = sample_reg[7:0];
  assign an_low = ~an_s;
  assign one_hot = (an_low != 8'h00) && ((an_low & (an_low - 8'h01)) == 8'h00);

  // A cnt_reg of zero only occurs straight after reset. In that case the
  // sample is treated as new even if the ports happen to match the cleared
  // register.
  assign port_changed = ({an, dec_cat} != sample_reg) || (cnt_reg == 8'd0);

  // The capture fires on the one cycle where the run of identical samples has
  // just reached its threshold. Leaving SETTLE guarantees one capture per dwell.
  assign capture     = (state_reg == SETTLE) && (cnt_reg == 8'(STABLE_CYCLES));
  assign anode_ok    = capture && one_hot;
  assign wrap        = anode_ok && have_last_reg && (idx_c <= last_idx_reg);
  assign timeout_hit = !anode_ok && (tcnt_reg >= TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    idx_c = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (an_low[i]) idx_c = 3'(i);
    end
  end

  always_comb begin
    seg_ok  = 1'b1;
    seg_val = 4'h0;
    case (cat_s[7:1])
      7'h01: seg_val = 4'h0;
      7'h4F: seg_val = 4'h1;
      7'h12: seg_val = 4'h2;
      7'h06: seg_val = 4'h3;
      7'h4C: seg_val = 4'h4;
      7'h24: seg_val = 4'h5;
      7'h20: seg_val = 4'h6;
      7'h0F: seg_val = 4'h7;
      7'h00: seg_val = 4'h8;
      7'h04: seg_val = 4'h9;
      7'h08: seg_val = 4'hA;
      7'h60: seg_val = 4'hB;
      7'h31: seg_val = 4'hC;
      7'h42: seg_val = 4'hD;
      7'h30: seg_val = 4'hE;
      7'h38: seg_val = 4'hF;
      default: seg_ok = 1'b0;
    endcase
  end

  assign seg_blank = (cat_s[7:1] == 7'h7F);
  assign seg_bad   = !seg_ok && !seg_blank;

  // Next snapshot. The frame clear is applied first so that the digit being
  // captured can still overwrite its own slot. A capture always beats the
  // timeout.
  always_comb begin
    val_next = digit_val;
    en_next  = digit_en;
    dp_next  = digit_dp;
    if (anode_ok) begin
      if (wrap) begin
        en_next = en_next & seen_reg;
        dp_next = dp_next & seen_reg;
      end
      en_next[idx_c]              = seg_ok;
      dp_next[idx_c]              = seg_bad ? 1'b0 : ~cat_s[0];
      val_next[{idx_c, 2'b00} +: 4] = seg_ok ? seg_val : 4'h0;
    end else if (timeout_hit) begin
      en_next = 8'h00;
      dp_next = 8'h00;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= BLANK;
      sample_reg    <= 16'h0000;
      cnt_reg       <= 8'd0;
      tcnt_reg      <= '0;
      seen_reg      <= 8'h00;
      last_idx_reg  <= 3'd0;
      have_last_reg <= 1'b0;
      digit_val     <= 32'h0;
      digit_en      <= 8'h00;
      digit_dp      <= 8'h00;
      frame_done    <= 1'b0;
      seg_error     <= 1'b0;
      stale         <= 1'b0;
    end else begin
      sample_reg <= {an, dec_cat};

      if (port_changed) begin
        cnt_reg   <= 8'd1;
        state_reg <= (an == 8'hFF) ? BLANK : SETTLE;
      end else begin
        if (cnt_reg < 8'(STABLE_CYCLES)) cnt_reg <= cnt_reg + 8'd1;
        if (capture) state_reg <= HELD;
      end

      digit_val  <= val_next;
      digit_en   <= en_next;
      digit_dp   <= dp_next;
      frame_done <= wrap;
      seg_error  <= capture && (!one_hot || seg_bad);

      if (anode_ok) begin
        tcnt_reg      <= '0;
        stale         <= 1'b0;
        seen_reg      <= (wrap ? 8'h00 : seen_reg) | (8'h01 << idx_c);
        last_idx_reg  <= idx_c;
        have_last_reg <= 1'b1;
      end else if (timeout_hit) begin
        tcnt_reg <= TW'(TIMEOUT_CYCLES);
        stale    <= 1'b1;
      end else begin
        tcnt_reg <= tcnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_decoder.sv
module tb_display_scan_decoder;

  localparam int STABLE  = 4;
  localparam int TIMEOUT = 100;
  localparam int LAT     = STABLE + 1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  an = 8'hFF;
  logic [7:0]  dec_cat = 8'hFF;
  logic [31:0] digit_val;
  logic [7:0]  digit_en;
  logic [7:0]  digit_dp;
  logic        frame_done;
  logic        seg_error;
  logic        stale;

  display_scan_decoder #(
    .STABLE_CYCLES(STABLE),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .an(an),
    .dec_cat(dec_cat),
    .digit_val(digit_val),
    .digit_en(digit_en),
    .digit_dp(digit_dp),
    .frame_done(frame_done),
    .seg_error(seg_error),
    .stale(stale)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  // Active-low a..g codes for hex 0..F.
  logic [6:0] seg_tbl [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                               7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  typedef struct {
    logic [31:0] val;
    logic [7:0]  en;
    logic [7:0]  dp;
    logic        fd;
    logic        se;
    logic        st;
    int          when;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  // Reference model of the visible snapshot.
  logic [31:0] m_val = '0;
  logic [7:0]  m_en = '0, m_dp = '0, m_seen = '0;
  logic        m_st = 1'b0, m_have = 1'b0;
  int          m_last = 0;
  int          last_cap = 0;
  logic [48:0] pushed_state = '0;
  logic [48:0] prev_state = '0;

  function automatic logic [7:0] cat_of(int v, bit dp_on);
    logic [6:0] s;
    s = seg_tbl[v];
    return {s, ~dp_on};
  endfunction

  function automatic logic [7:0] an_of(int d);
    logic [7:0] one;
    one = 8'h01 << d;
    return ~one;
  endfunction

  task automatic push_evt(input bit fd, input bit se, input int when);
    exp_t e;
    logic [48:0] cur;
    cur = {m_val, m_en, m_dp, m_st};
    if (cur != pushed_state || fd || se) begin
      e.val = m_val; e.en = m_en; e.dp = m_dp;
      e.fd = fd; e.se = se; e.st = m_st; e.when = when;
      exp_q.push_back(e);
    end
    pushed_state = cur;
  endtask

  task automatic model_capture(input logic [7:0] a, input logic [7:0] c, input int when);
    int idx;
    bit fd, se, found;
    int k;
    if ($countones(~a) != 1) begin
      push_evt(1'b0, 1'b1, when);
      return;
    end
    idx = 0;
    for (int i = 0; i < 8; i++) if (!a[i]) idx = i;
    fd = m_have && (idx <= m_last);
    if (fd) begin
      m_en = m_en & m_seen;
      m_dp = m_dp & m_seen;
      m_seen = 8'h00;
    end
    m_seen[idx] = 1'b1;
    m_last = idx;
    m_have = 1'b1;
    m_st = 1'b0;
    last_cap = when;
    found = 1'b0; k = 0; se = 1'b0;
    for (int j = 0; j < 16; j++) if (seg_tbl[j] == c[7:1]) begin found = 1'b1; k = j; end
    if (found) begin
      m_val[idx*4 +: 4] = 4'(k);
      m_en[idx] = 1'b1;
      m_dp[idx] = ~c[0];
    end else if (c[7:1] == 7'h7F) begin
      m_val[idx*4 +: 4] = 4'h0;
      m_en[idx] = 1'b0;
      m_dp[idx] = ~c[0];
    end else begin
      m_val[idx*4 +: 4] = 4'h0;
      m_en[idx] = 1'b0;
      m_dp[idx] = 1'b0;
      se = 1'b1;
    end
    push_evt(fd, se, when);
  endtask

  // Drive one bus value for n cycles; a long enough lit dwell is expected
  // to show up at the outputs LAT edges after it is applied.
  task automatic dwell(input logic [7:0] a, input logic [7:0] c, input int n);
    int t0;
    t0 = cyc;
    an = a;
    dec_cat = c;
    if (n >= STABLE && a != 8'hFF) model_capture(a, c, t0 + LAT);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic scan(input int base, input bit dp7, input logic [7:0] skip);
    dwell(8'hFF, 8'hFF, 4);
    for (int d = 0; d < 8; d++) begin
      if (skip[d]) dwell(8'hFF, 8'hFF, 8);
      else dwell(an_of(d), cat_of(base + d, dp7 && d == 7), 8);
    end
    dwell(an_of(0), cat_of(base, 1'b0), 8);
  endtask

  // Monitor: any change of the held outputs, or any pulse, is one DUT event.
  always @(negedge clock) begin
    if (mon_en) begin
      logic [48:0] cur;
      exp_t e;
      cur = {digit_val, digit_en, digit_dp, stale};
      if (cur !== prev_state || frame_done !== 1'b0 || seg_error !== 1'b0) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: got val=%h en=%h dp=%h fd=%b se=%b stale=%b at cyc %0d, required no event",
                   digit_val, digit_en, digit_dp, frame_done, seg_error, stale, cyc);
        end else begin
          e = exp_q.pop_front();
          if (digit_val !== e.val || digit_en !== e.en || digit_dp !== e.dp ||
              frame_done !== e.fd || seg_error !== e.se || stale !== e.st || cyc != e.when) begin
            n_fail++;
            $display("FAIL event: got val=%h en=%h dp=%h fd=%b se=%b stale=%b cyc=%0d, required val=%h en=%h dp=%h fd=%b se=%b stale=%b cyc=%0d",
                     digit_val, digit_en, digit_dp, frame_done, seg_error, stale, cyc,
                     e.val, e.en, e.dp, e.fd, e.se, e.st, e.when);
          end else begin
            $display("event ok cyc=%0d val=%h en=%h dp=%h fd=%b se=%b stale=%b",
                     cyc, digit_val, digit_en, digit_dp, frame_done, seg_error, stale);
          end
        end
      end
      prev_state = cur;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if (digit_val !== 32'h0 || digit_en !== 8'h00 || digit_dp !== 8'h00 ||
        frame_done !== 1'b0 || seg_error !== 1'b0 || stale !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got val=%h en=%h dp=%h fd=%b se=%b stale=%b, required all zero",
               digit_val, digit_en, digit_dp, frame_done, seg_error, stale);
    end
    reset = 1'b0;
    prev_state = '0;
    mon_en = 1'b1;

    // Single digit 1 on position 0, dp off.
    dwell(8'hFE, 8'h9F, 10);

    // Full frame 0..7, dp on digit 7, then revisit digit 0.
    scan(0, 1'b1, 8'h00);

    // Same frame with digits 2 and 5 never driven.
    scan(0, 1'b1, 8'h24);

    // Short dwell, illegal anode, illegal segment pattern.
    dwell(an_of(1), cat_of(9, 1'b0), 3);
    dwell(8'hFF, 8'hFF, 4);
    dwell(8'hFC, cat_of(8, 1'b0), 6);
    dwell(an_of(1), 8'hFD, 8);

    // Valid capture, then silence until the timeout.
    dwell(an_of(4), cat_of(12, 1'b0), 8);
    m_en = 8'h00;
    m_dp = 8'h00;
    m_st = 1'b1;
    push_evt(1'b0, 1'b0, last_cap + TIMEOUT);
    dwell(8'hFF, 8'hFF, last_cap + TIMEOUT + 3 - cyc);
    dwell(an_of(3), cat_of(10, 1'b0), 8);

    // Full frame, then reset in the middle of a dwell.
    scan(8, 1'b0, 8'h00);
    dwell(an_of(2), cat_of(5, 1'b0), 2);
    reset = 1'b1;
    m_val = '0; m_en = '0; m_dp = '0; m_st = 1'b0;
    m_seen = '0; m_have = 1'b0; m_last = 0;
    push_evt(1'b0, 1'b0, cyc + 1);
    @(posedge clock); #1;
    reset = 1'b0;
    dwell(an_of(2), cat_of(5, 1'b0), 8);
    dwell(8'hFF, 8'hFF, 10);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_events: got %0d expected events never seen, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scan_decoder.md
Name: display_scan_decoder

Overview:
- Passive receiver for the 8-digit multiplexed seven-segment bus (an, dec_cat) that the alarm top drives.
- Watches the anode/cathode scan, decodes each stable digit back to its 4-bit hex value, enable and dp, and presents a full 8-digit snapshot.
- Serves as an on-chip self-check / debug tap: FSM state, timer state and countdown become readable without a camera or ILA.
- Operates on the same clock as the display driver and is purely observational; it never drives the display bus.

Parameters:
- STABLE_CYCLES, 4: consecutive identical registered samples required before a digit is captured (range 2..255).
- TIMEOUT_CYCLES, 1000000: cycles without any capture before the snapshot is declared stale.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- an  in  8  anode selects, active-low; bit i = digit i.
- dec_cat  in  8  cathodes, active-low; [7:1] = segments a..g, [0] = dp.
- digit_val  out  32  decoded hex; digit i at [4i+3:4i].
- digit_en  out  8  digit i currently lit with a recognised pattern.
- digit_dp  out  8  digit i decimal point lit.
- frame_done  out  1  one-cycle pulse on scan wrap-around.
- seg_error  out  1  one-cycle pulse on an illegal anode or segment pattern.
- stale  out  1  no capture for TIMEOUT_CYCLES cycles.

Behaviour:
- Reset values: digit_val=0, digit_en=0, digit_dp=0, frame_done=0, seg_error=0, stale=0, all internal state cleared. Reset mid-scan discards any partial dwell.
- Input stage: {an, dec_cat} is registered once.
- Stability counter:
  - Clears when the registered sample differs from the previous registered sample; otherwise increments, saturating.
  - A capture fires exactly once per dwell, when the count of identical samples reaches STABLE_CYCLES.
  - Outputs update on the clock edge STABLE_CYCLES+1 edges after a new value appears at the ports.
- State machine:
  - BLANK: an=8'hFF or no dwell yet.
  - SETTLE: counting identical samples.
  - HELD: captured; waits for the sample to change, then returns to SETTLE or BLANK.
- Anode legality, checked at capture:
  - Exactly one zero bit → index = position of the zero.
  - an=8'hFF → no capture and no error.
  - Two or more zeros → seg_error pulse; no digit is updated.
- Segment decode uses the standard hex table (a..g active-low), e.g. 0=7'b0000001, 1=7'b1001111, 8=7'b0000000, A=7'b0001000, F=7'b0111000.
  - Recognised pattern → digit_val[i]=value, digit_en[i]=1, digit_dp[i]=~dec_cat[0].
  - All segments off (7'h7F) → digit_en[i]=0, digit_val[i]=0, digit_dp[i]=~dec_cat[0]; no error.
  - Unrecognised pattern → seg_error pulse, digit_en[i]=0, digit_val[i]=0.
- Frame tracking:
  - A seen mask records the indices captured since the last wrap.
  - A capture whose index is <= the last captured index is a wrap: frame_done pulses on the cycle after that capture.
  - On a wrap, digits not in the seen mask get digit_en=0 and digit_dp=0; their digit_val is held. The mask then restarts with the current index.
  - The first capture after reset never produces frame_done.
  - A digit whose anode is never driven (disabled display position) therefore reads digit_en=0 after one frame.
- Stale timeout:
  - A counter increments every cycle and clears on any capture.
  - On reaching TIMEOUT_CYCLES: stale=1, digit_en=0, digit_dp=0.
  - stale stays high until the next successful capture; it clears in the same cycle that capture updates the outputs.
- Simultaneous events: if a capture and the timeout coincide, the capture wins. If a wrap and an illegal pattern coincide, both pulses fire and the frame clear still applies.

Test Plan:
- Hold an=8'hFE, dec_cat=8'h9F for 10 cycles → digit_val[3:0]=1, digit_en[0]=1, digit_dp[0]=0; first update on edge STABLE_CYCLES+1=5.
- Scan digits 0..7 with values 0..7 (dp on digit 7, dec_cat[0]=0), each held 8 cycles, then revisit digit 0 → digit_val=32'h76543210, digit_en=8'hFF, digit_dp=8'h80, one frame_done pulse on the cycle after the digit-0 capture.
- Same scan but skip digits 2 and 5 (an=8'hFF during their slots) → after the wrap, digit_en=8'hDB and no seg_error.
- Dwell shorter than STABLE_CYCLES (3 cycles) → no capture. an=8'hFC held 6 cycles → one seg_error pulse, outputs unchanged. Pattern 7'b1111110 on digit 1 → seg_error, digit_en[1]=0.
- Stop all scanning (an=8'hFF) with TIMEOUT_CYCLES=100 → stale=1 at cycle 100, digit_en=0. The next valid dwell clears stale and sets that digit's enable.
- Assert reset for 1 cycle mid-dwell after a full frame → all outputs 0 next cycle; a subsequent first capture produces no frame_done.
